// File: rtl/axi_reg_bridge_pkg.sv
// Shared definitions for the AXI to register-bus bridge.
//   bridge_state_e : bridge FSM state encoding
//   BURST_*        : AXI burst type encodings
//   RESP_*         : AXI response encodings
//   burst_supported: true for burst types the bridge can walk (FIXED, INCR)
package axi_reg_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_DATA,
      ST_WR_RESP,
      ST_RD_ACCESS,
      ST_RD_DATA
   } bridge_state_e;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   function automatic logic burst_supported(input logic [1:0] burst);
      return (burst == BURST_FIXED) || (burst == BURST_INCR);
   endfunction

endpackage

// File: rtl/axi_reg_bus_bridge.sv
// AXI slave to simple register bus bridge. One transaction in flight; bursts
// are walked one register word per beat.
//
// Ports
//   i_clk, i_reset_n          : clock, async active-low reset
//   AW / W / B                : AXI write address, data, response channels
//   AR / R                    : AXI read address, data channels
//   o_reg_addr                : register word index
//   o_reg_wdata, o_reg_wstrb  : write data and byte strobes
//   o_reg_wr, o_reg_rd        : single-cycle write / read strobes
//   i_reg_rdata               : read data, valid the cycle after o_reg_rd
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | waiting for AW or AR; round-robin on collision
// ST_WR_DATA   | accepting W beats, one o_reg_wr per beat
// ST_WR_RESP   | presenting B until i_bready
// ST_RD_ACCESS | cycle 0: pulse o_reg_rd; cycle 1: capture i_reg_rdata
// ST_RD_DATA   | presenting R beat until i_rready
module axi_reg_bus_bridge
   import axi_reg_bridge_pkg::*;
#(
   parameter int DATA_WIDTH     = 64,
   parameter int ADDR_WIDTH     = 28,
   parameter int ID_WIDTH       = 8,
   parameter int REG_ADDR_WIDTH = 8
) (
   input  logic                      i_clk,
   input  logic                      i_reset_n,

   input  logic                      i_awvalid,
   input  logic [ADDR_WIDTH-1:0]     i_awaddr,
   input  logic [ID_WIDTH-1:0]       i_awid,
   input  logic [7:0]                i_awlen,
   input  logic [1:0]                i_awburst,
   output logic                      o_awready,

   input  logic                      i_wvalid,
   input  logic [DATA_WIDTH-1:0]     i_wdata,
   input  logic [DATA_WIDTH/8-1:0]   i_wstrb,
   input  logic                      i_wlast,
   output logic                      o_wready,

   output logic                      o_bvalid,
   output logic [1:0]                o_bresp,
   output logic [ID_WIDTH-1:0]       o_bid,
   input  logic                      i_bready,

   input  logic                      i_arvalid,
   input  logic [ADDR_WIDTH-1:0]     i_araddr,
   input  logic [ID_WIDTH-1:0]       i_arid,
   input  logic [7:0]                i_arlen,
   input  logic [1:0]                i_arburst,
   output logic                      o_arready,

   output logic                      o_rvalid,
   output logic [DATA_WIDTH-1:0]     o_rdata,
   output logic [1:0]                o_rresp,
   output logic [ID_WIDTH-1:0]       o_rid,
   output logic                      o_rlast,
   input  logic                      i_rready,

   output logic [REG_ADDR_WIDTH-1:0] o_reg_addr,
   output logic [DATA_WIDTH-1:0]     o_reg_wdata,
   output logic [DATA_WIDTH/8-1:0]   o_reg_wstrb,
   output logic                      o_reg_wr,
   output logic                      o_reg_rd,
   input  logic [DATA_WIDTH-1:0]     i_reg_rdata
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int LSB        = $clog2(STRB_WIDTH);

   bridge_state_e             state_q, state_d;
   logic                      prio_wr_q;
   logic [ID_WIDTH-1:0]       id_q;
   logic [7:0]                beats_left_q;
   logic                      burst_ok_q;
   logic                      incr_q;
   logic                      err_q;
   logic                      rd_wait_q;
   logic [REG_ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0]     rdata_q;
   logic                      grant_wr, grant_rd;
   logic                      last_beat;

   // Only the word-index slice of the AXI addresses is decoded.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{i_awaddr, i_araddr};

   assign last_beat = (beats_left_q == 8'd0);

   assign o_bresp = err_q ? RESP_SLVERR : RESP_OKAY;
   assign o_rresp = err_q ? RESP_SLVERR : RESP_OKAY;
   assign o_bid   = id_q;
   assign o_rid   = id_q;
   assign o_rdata = rdata_q;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_wr  = 1'b0;
      grant_rd  = 1'b0;
      o_awready = 1'b0;
      o_arready = 1'b0;
      o_wready  = 1'b0;
      o_bvalid  = 1'b0;
      o_rvalid  = 1'b0;
      o_rlast   = 1'b0;
      o_reg_rd  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_awvalid && (prio_wr_q || !i_arvalid)) begin
               grant_wr  = 1'b1;
               o_awready = 1'b1;
               state_d   = ST_WR_DATA;
            end else if (i_arvalid) begin
               grant_rd  = 1'b1;
               o_arready = 1'b1;
               state_d   = ST_RD_ACCESS;
            end
         end
         ST_WR_DATA: begin
            o_wready = 1'b1;
            if (i_wvalid && last_beat) begin
               state_d = ST_WR_RESP;
            end
         end
         ST_WR_RESP: begin
            o_bvalid = 1'b1;
            if (i_bready) begin
               state_d = ST_IDLE;
            end
         end
         ST_RD_ACCESS: begin
            // Unsupported bursts still walk the beats but never touch registers.
            o_reg_rd = !rd_wait_q && burst_ok_q;
            if (rd_wait_q) begin
               state_d = ST_RD_DATA;
            end
         end
         ST_RD_DATA: begin
            o_rvalid = 1'b1;
            o_rlast  = last_beat;
            if (i_rready) begin
               state_d = last_beat ? ST_IDLE : ST_RD_ACCESS;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         prio_wr_q    <= 1'b1;
         id_q         <= '0;
         beats_left_q <= '0;
         burst_ok_q   <= 1'b0;
         incr_q       <= 1'b0;
         err_q        <= 1'b0;
         rd_wait_q    <= 1'b0;
         addr_q       <= '0;
         rdata_q      <= '0;
         o_reg_addr   <= '0;
         o_reg_wdata  <= '0;
         o_reg_wstrb  <= '0;
         o_reg_wr     <= 1'b0;
      end else begin
         o_reg_wr <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (i_awvalid && i_arvalid) begin
                  prio_wr_q <= ~prio_wr_q;
               end
               if (grant_wr) begin
                  id_q         <= i_awid;
                  beats_left_q <= i_awlen;
                  burst_ok_q   <= burst_supported(i_awburst);
                  incr_q       <= (i_awburst == BURST_INCR);
                  err_q        <= !burst_supported(i_awburst);
                  addr_q       <= i_awaddr[LSB +: REG_ADDR_WIDTH];
               end else if (grant_rd) begin
                  id_q         <= i_arid;
                  beats_left_q <= i_arlen;
                  burst_ok_q   <= burst_supported(i_arburst);
                  incr_q       <= (i_arburst == BURST_INCR);
                  err_q        <= !burst_supported(i_arburst);
                  rd_wait_q    <= 1'b0;
                  o_reg_addr   <= i_araddr[LSB +: REG_ADDR_WIDTH];
               end
            end
            ST_WR_DATA: begin
               if (i_wvalid) begin
                  o_reg_wr    <= burst_ok_q;
                  o_reg_addr  <= addr_q;
                  o_reg_wdata <= i_wdata;
                  o_reg_wstrb <= i_wstrb;
                  if (incr_q) begin
                     addr_q <= addr_q + REG_ADDR_WIDTH'(1);
                  end
                  // The count, not wlast, ends the burst; a disagreement only taints bresp.
                  if (i_wlast != last_beat) begin
                     err_q <= 1'b1;
                  end
                  if (!last_beat) begin
                     beats_left_q <= beats_left_q - 8'd1;
                  end
               end
            end
            ST_RD_ACCESS: begin
               if (!rd_wait_q) begin
                  rd_wait_q <= 1'b1;
               end else begin
                  rd_wait_q <= 1'b0;
                  rdata_q   <= burst_ok_q ? i_reg_rdata : '0;
               end
            end
            ST_RD_DATA: begin
               if (i_rready && !last_beat) begin
                  beats_left_q <= beats_left_q - 8'd1;
                  if (incr_q) begin
                     o_reg_addr <= o_reg_addr + REG_ADDR_WIDTH'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
